// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue unit: state encoding,
// default widths and reset values.
package alu_issue_pkg;

   localparam int W_DEF  = 4;
   localparam int AW_DEF = 3;
   localparam int OP_W   = 4;
   localparam int COND_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WB    = 2'd2
   } state_e;

   localparam logic [OP_W-1:0]   OP_RST    = '0;
   localparam logic [COND_W-1:0] FLAGS_RST = '0;

endpackage

// File: rtl/alu_issue_unit_regfile.sv
// Register file for the issue unit: 2**AW x W entries, two operand read
// ports, a debug read port and one write port; r0 is hardwired to zero.
module alu_issue_regfile
   import alu_issue_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_a_i,
   output logic [W-1:0]  rdata_a_o,
   input  logic [AW-1:0] raddr_b_i,
   output logic [W-1:0]  rdata_b_o,
   input  logic [AW-1:0] dbg_addr_i,
   output logic [W-1:0]  dbg_data_o
);

   localparam int NREG = 2**AW;

   logic [W-1:0] mem_q [NREG];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != '0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // r0 is forced on every read port so it never depends on storage contents.
   assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : mem_q[raddr_a_i];
   assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : mem_q[raddr_b_i];
   assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_unit.sv
// Three-state issue unit: reads operands from the register file, drives an
// external ALU for one cycle, then writes the result back and pulses done.
//
//   state | meaning
//   IDLE  | ready for an instruction; alu_* hold last issued values
//   ISSUE | operands presented to ALU; result and flags captured at exit
//   WB    | writeback visible, done pulses, returns to IDLE
module alu_issue_unit
   import alu_issue_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int AW = AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [AW-1:0]     in_rd,
   input  logic [AW-1:0]     in_rs1,
   input  logic [AW-1:0]     in_rs2,
   input  logic              in_imm_en,
   input  logic [W-1:0]      in_imm,
   output logic [W-1:0]      alu_a,
   output logic [W-1:0]      alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [W-1:0]      alu_c,
   input  logic [COND_W-1:0] alu_cond,
   output logic [COND_W-1:0] flags,
   output logic              busy,
   output logic              done,
   input  logic [AW-1:0]     dbg_addr,
   output logic [W-1:0]      dbg_data
);

   state_e              state_q;
   logic [W-1:0]        alu_a_q;
   logic [W-1:0]        alu_b_q;
   logic [OP_W-1:0]     alu_op_q;
   logic [AW-1:0]       rd_q;
   logic [COND_W-1:0]   flags_q;
   logic                done_q;

   logic [W-1:0]        rs1_data;
   logic [W-1:0]        rs2_data;
   logic [W-1:0]        opb_d;
   logic                rf_we;

   alu_issue_regfile #(
      .W  (W),
      .AW (AW)
   ) u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .we_i       (rf_we),
      .waddr_i    (rd_q),
      .wdata_i    (alu_c),
      .raddr_a_i  (in_rs1),
      .rdata_a_o  (rs1_data),
      .raddr_b_i  (in_rs2),
      .rdata_b_o  (rs2_data),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data)
   );

   assign opb_d = in_imm_en ? in_imm : rs2_data;

   // Writeback happens at the edge that closes ISSUE; a reset at that edge
   // wins inside the register file, so an aborted op leaves no trace.
   assign rf_we = (state_q == ISSUE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= OP_RST;
         rd_q     <= '0;
         flags_q  <= FLAGS_RST;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (in_valid) begin
                  alu_a_q  <= rs1_data;
                  alu_b_q  <= opb_d;
                  alu_op_q <= in_op;
                  rd_q     <= in_rd;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: begin
               flags_q <= alu_cond;
               done_q  <= 1'b1;
               state_q <= WB;
            end
            WB: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_op   = alu_op_q;
   assign flags    = flags_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: directed cases plus randomized
// instructions checked against an architectural register/flags model.
module tb_alu_issue_unit;

   localparam int W  = 4;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_op;
   logic [AW-1:0] in_rd, in_rs1, in_rs2;
   logic          in_imm_en;
   logic [W-1:0]  in_imm;
   logic [W-1:0]  alu_a, alu_b;
   logic [3:0]    alu_op;
   logic [W-1:0]  alu_c;
   logic [3:0]    alu_cond;
   logic [3:0]    flags;
   logic          busy, done;
   logic [AW-1:0] dbg_addr;
   logic [W-1:0]  dbg_data;

   int n_tests = 0;
   int n_fail  = 0;

   int ref_rf [8];
   int ref_flags;

   alu_issue_unit #(.W(W), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_imm_en (in_imm_en),
      .in_imm    (in_imm),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_c     (alu_c),
      .alu_cond  (alu_cond),
      .flags     (flags),
      .busy      (busy),
      .done      (done),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dbg_read(input int addr, output int data);
      dbg_addr = addr[AW-1:0];
      #1;
      data = int'(dbg_data);
   endtask

   task automatic check_all_regs(input string tag);
      int d;
      for (int r = 0; r < 8; r++) begin
         dbg_read(r, d);
         chk($sformatf("%s_r%0d", tag, r), d, ref_rf[r]);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 8; r++) ref_rf[r] = 0;
      ref_flags = 0;
   endtask

   task automatic drive_junk();
      in_op     = 4'($urandom_range(0, 15));
      in_rd     = AW'($urandom_range(0, 7));
      in_rs1    = AW'($urandom_range(0, 7));
      in_rs2    = AW'($urandom_range(0, 7));
      in_imm_en = 1'($urandom_range(0, 1));
      in_imm    = W'($urandom_range(0, 15));
   endtask

   // Called one step after an edge while the unit is IDLE; returns in the
   // IDLE cycle following writeback.
   task automatic issue(input int op, input int rd, input int rs1, input int rs2,
                        input int imm_en, input int imm, input int c, input int cond,
                        input bit hold_valid);
      int exp_a, exp_b, d;
      chk("ready_before_accept", int'(in_ready), 1);
      exp_a = ref_rf[rs1];
      exp_b = (imm_en != 0) ? imm : ref_rf[rs2];
      in_valid  = 1'b1;
      in_op     = op[3:0];
      in_rd     = rd[AW-1:0];
      in_rs1    = rs1[AW-1:0];
      in_rs2    = rs2[AW-1:0];
      in_imm_en = imm_en[0];
      in_imm    = imm[W-1:0];
      tick();
      // ISSUE
      if (hold_valid) drive_junk(); else in_valid = 1'b0;
      alu_c    = c[W-1:0];
      alu_cond = cond[3:0];
      chk("issue_alu_a", int'(alu_a), exp_a);
      chk("issue_alu_b", int'(alu_b), exp_b);
      chk("issue_alu_op", int'(alu_op), op);
      chk("issue_busy", int'(busy), 1);
      chk("issue_ready", int'(in_ready), 0);
      chk("issue_done", int'(done), 0);
      dbg_read(rd, d);
      chk("issue_dbg_old", d, ref_rf[rd]);
      tick();
      // WB
      if (rd != 0) ref_rf[rd] = c;
      ref_flags = cond;
      alu_c    = W'($urandom_range(0, 15));
      alu_cond = 4'($urandom_range(0, 15));
      if (hold_valid) drive_junk();
      chk("wb_done", int'(done), 1);
      chk("wb_ready", int'(in_ready), 0);
      chk("wb_flags", int'(flags), ref_flags);
      chk("wb_alu_a_hold", int'(alu_a), exp_a);
      chk("wb_alu_b_hold", int'(alu_b), exp_b);
      dbg_read(rd, d);
      chk("wb_dbg_new", d, ref_rf[rd]);
      tick();
      // back in IDLE
      in_valid = 1'b0;
      chk("idle_done", int'(done), 0);
      chk("idle_ready", int'(in_ready), 1);
      chk("idle_busy", int'(busy), 0);
      chk("idle_alu_op_hold", int'(alu_op), op);
   endtask

   initial begin
      int d;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_imm_en = 1'b0; in_imm = '0;
      alu_c = '0; alu_cond = '0; dbg_addr = '0;
      model_reset();

      // reset held two cycles
      tick();
      tick();
      chk("rst_alu_a", int'(alu_a), 0);
      chk("rst_alu_b", int'(alu_b), 0);
      chk("rst_alu_op", int'(alu_op), 0);
      chk("rst_flags", int'(flags), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      check_all_regs("rst");
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", int'(in_ready), 1);
      chk("post_rst_busy", int'(busy), 0);

      // immediate operand
      issue(1, 1, 0, 0, 1, 5, 5, 0, 1'b0);
      // register operands
      issue(0, 2, 0, 0, 1, 3, 3, 0, 1'b0);
      issue(2, 3, 1, 2, 0, 0, 8, 10, 1'b0);
      chk("regop_flags", int'(flags), 10);
      // r0 destination still updates flags
      issue(4, 0, 1, 3, 0, 0, 15, 1, 1'b0);
      dbg_read(0, d);
      chk("r0_stays_zero", d, 0);
      chk("r0_flags", int'(flags), 1);
      // backpressure: valid held with changing fields, back-to-back accepts
      issue(3, 4, 3, 1, 0, 0, 6, 2, 1'b1);
      issue(5, 5, 4, 0, 1, 9, 12, 4, 1'b1);
      check_all_regs("bp");

      // reset during ISSUE aborts the op
      in_valid = 1'b1;
      in_op = 4'd7; in_rd = 3'd6; in_rs1 = 3'd1; in_rs2 = 3'd2;
      in_imm_en = 1'b0; in_imm = '0;
      tick();
      in_valid = 1'b0;
      alu_c = 4'hF; alu_cond = 4'hF;
      chk("abort_in_issue", int'(busy), 1);
      rst_n = 1'b0;
      tick();
      model_reset();
      chk("abort_done", int'(done), 0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("abort_no_done", int'(done), 0);
         tick();
      end
      chk("abort_flags", int'(flags), 0);
      chk("abort_ready", int'(in_ready), 1);
      check_all_regs("abort");

      // randomized instructions
      for (int n = 0; n < 40; n++) begin
         issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)));
         if (n % 8 == 7) check_all_regs("rand");
      end
      check_all_regs("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
